// File: rtl/seg_scan_display.sv
// Multiplexed common-anode 7-segment driver for two binary fields.
// Serial double-dabble conversion, prescaled digit scan and blink, all on CLOCK.
module seg_scan_display #(
    parameter int unsigned DIGITS_PER_FIELD = 2,
    parameter int unsigned FIELD_W          = 8,
    parameter int unsigned SCAN_DIV         = 1,
    parameter int unsigned BLINK_DIV        = 125
) (
    input  logic                            CLOCK,
    input  logic                            RESET,
    input  logic                            ENABLE,
    input  logic [FIELD_W-1:0]              FIELD_A,
    input  logic [FIELD_W-1:0]              FIELD_B,
    input  logic [1:0]                      BLINK_MASK,
    input  logic                            BLANK_LZ,
    output logic [6:0]                      seg,
    output logic [2*DIGITS_PER_FIELD-1:0]   an,
    output logic                            conv_done
);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int unsigned N          = 2 * DIGITS_PER_FIELD;
    localparam int unsigned IDX_W      = $clog2(N);
    localparam int unsigned SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned CNT_W      = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;
    localparam int unsigned BIN_DIGITS = (FIELD_W + 2) / 3;
    localparam int unsigned BCD_DIGITS = (BIN_DIGITS > DIGITS_PER_FIELD) ? BIN_DIGITS : DIGITS_PER_FIELD;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned DISP_W     = 4 * DIGITS_PER_FIELD;
    localparam longint unsigned MAX_VAL = pow10(DIGITS_PER_FIELD) - 1;

    typedef enum logic [1:0] {IDLE, CONV_A, CONV_B, COMMIT} conv_state_t;

    // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < int'(BCD_DIGITS); i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    conv_state_t        state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_last;
    logic [FIELD_W-1:0] snap_a, snap_b;
    logic [BCD_W-1:0]   bcd_a, bcd_b;
    logic               wovf_a, wovf_b;
    logic [DISP_W-1:0]  disp_a, disp_b;
    logic               ovf_a, ovf_b;

    logic [SCAN_W-1:0]  presc;
    logic [IDX_W-1:0]   idx;
    logic [BLINK_W-1:0] bcnt;
    logic               phase;

    logic               sel_a, fld_ovf, lz_zero, blink_off, lz_off, show;
    logic [IDX_W-1:0]   pos;
    logic [DISP_W-1:0]  fld;
    logic [3:0]         nib;
    logic [6:0]         seg_c;
    logic [N-1:0]       an_c;

    // Converter state register
    always_ff @(posedge CLOCK) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        cnt_last   = (cnt == CNT_W'(FIELD_W - 1));
        case (state)
            IDLE:    next_state = CONV_A;
            CONV_A:  if (cnt_last) next_state = CONV_B;
            CONV_B:  if (cnt_last) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Converter datapath and display registers
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt       <= '0;
            snap_a    <= '0;
            snap_b    <= '0;
            bcd_a     <= '0;
            bcd_b     <= '0;
            wovf_a    <= 1'b0;
            wovf_b    <= 1'b0;
            disp_a    <= '0;
            disp_b    <= '0;
            ovf_a     <= 1'b0;
            ovf_b     <= 1'b0;
            conv_done <= 1'b0;
        end else begin
            conv_done <= (state == COMMIT);
            case (state)
                IDLE: begin
                    snap_a <= FIELD_A;
                    snap_b <= FIELD_B;
                    wovf_a <= (64'(FIELD_A) > MAX_VAL);
                    wovf_b <= (64'(FIELD_B) > MAX_VAL);
                    bcd_a  <= '0;
                    bcd_b  <= '0;
                    cnt    <= '0;
                end
                CONV_A: begin
                    bcd_a  <= BCD_W'({add3(bcd_a), snap_a[FIELD_W-1]});
                    snap_a <= snap_a << 1;
                    cnt    <= cnt_last ? '0 : cnt + CNT_W'(1);
                end
                CONV_B: begin
                    bcd_b  <= BCD_W'({add3(bcd_b), snap_b[FIELD_W-1]});
                    snap_b <= snap_b << 1;
                    cnt    <= cnt_last ? '0 : cnt + CNT_W'(1);
                end
                COMMIT: begin
                    disp_a <= bcd_a[DISP_W-1:0];
                    disp_b <= bcd_b[DISP_W-1:0];
                    ovf_a  <= wovf_a;
                    ovf_b  <= wovf_b;
                end
                default: ;
            endcase
        end
    end

    // Scan prescaler/index and blink phase
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            presc <= '0;
            idx   <= '0;
            bcnt  <= '0;
            phase <= 1'b1;
        end else begin
            if (presc == SCAN_W'(SCAN_DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                presc <= presc + SCAN_W'(1);
            end
            if (bcnt == BLINK_W'(BLINK_DIV - 1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt  <= bcnt + BLINK_W'(1);
            end
        end
    end

    // Digit decode for the current scan index
    always_comb begin
        sel_a   = (idx >= IDX_W'(DIGITS_PER_FIELD));
        pos     = sel_a ? idx - IDX_W'(DIGITS_PER_FIELD) : idx;
        fld     = sel_a ? disp_a : disp_b;
        fld_ovf = sel_a ? ovf_a : ovf_b;
        nib     = 4'd0;
        lz_zero = 1'b1;
        for (int j = 0; j < int'(DIGITS_PER_FIELD); j++) begin
            if (IDX_W'(j) == pos) nib = fld[4*j +: 4];
            if (IDX_W'(j) >= pos && fld[4*j +: 4] != 4'd0) lz_zero = 1'b0;
        end
        blink_off = !phase && (sel_a ? BLINK_MASK[1] : BLINK_MASK[0]);
        lz_off    = BLANK_LZ && !fld_ovf && (pos != '0) && lz_zero;
        show      = ENABLE && !blink_off && !lz_off;
        seg_c     = !show ? 7'b1111111 : (fld_ovf ? 7'b0111111 : seg_code(nib));
        an_c      = show ? ~(N'(1) << idx) : '1;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            seg <= 7'b1111111;
            an  <= '1;
        end else begin
            seg <= seg_c;
            an  <= an_c;
        end
    end

endmodule
